// File: rtl/mfp_ahb_uart_tx.sv
// AHB-Lite slave UART transmitter: bus writes fill a TX FIFO that an 8N1 serializer
// drains onto UART_TX, LSB first, line idle high.
module mfp_ahb_uart_tx #(
   parameter int FIFO_DEPTH  = 16,
   parameter int DEFAULT_DIV = 434
) (
   input  logic        HCLK,
   input  logic        SI_Reset,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic        UART_TX,
   output logic        TX_IRQ
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic          dp_sel_q, dp_write_q;
   logic [1:0]    dp_addr_q;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q;
   logic          ovf_q;
   logic [15:0]   bauddiv_q;
   state_t        state_q, state_d;
   logic [15:0]   baud_q, baud_d, div_q, div_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d, irq_q, irq_d;
   logic          wr_en_s, push_s, push_ok_s, pop_s, full_s, empty_s, baud_end_s;
   logic [31:0]   status_s;
   logic          unused_s;

   assign unused_s  = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};
   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;
   assign UART_TX   = tx_q;
   assign TX_IRQ    = irq_q;

   assign wr_en_s    = dp_sel_q & dp_write_q;
   assign push_s     = wr_en_s & (dp_addr_q == 2'd0);
   assign full_s     = (count_q == CW'(FIFO_DEPTH));
   assign empty_s    = (count_q == {CW{1'b0}});
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
   assign push_ok_s  = push_s & (~full_s | pop_s);
   assign baud_end_s = (baud_q == (div_q - 16'd1));

   always_ff @(posedge HCLK) begin
      if (SI_Reset) begin
         dp_sel_q   <= 1'b0;
         dp_write_q <= 1'b0;
         dp_addr_q  <= 2'd0;
      end else if (HREADY) begin
         dp_sel_q   <= HSEL & HTRANS[1];
         dp_write_q <= HWRITE;
         dp_addr_q  <= HADDR[3:2];
      end
   end

   always_ff @(posedge HCLK) begin
      if (push_ok_s && !SI_Reset) mem_q[wptr_q] <= HWDATA[7:0];
   end

   always_ff @(posedge HCLK) begin
      if (SI_Reset) begin
         wptr_q    <= {AW{1'b0}};
         rptr_q    <= {AW{1'b0}};
         count_q   <= {CW{1'b0}};
         ovf_q     <= 1'b0;
         bauddiv_q <= 16'(DEFAULT_DIV);
      end else begin
         if (push_ok_s) wptr_q <= wptr_q + 1'b1;
         if (pop_s)     rptr_q <= rptr_q + 1'b1;
         case ({push_ok_s, pop_s})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (push_s && full_s && !pop_s)
            ovf_q <= 1'b1;
         else if (wr_en_s && dp_addr_q == 2'd1 && HWDATA[3])
            ovf_q <= 1'b0;
         if (wr_en_s && dp_addr_q == 2'd2)
            bauddiv_q <= (HWDATA[15:0] < 16'd2) ? 16'd2 : HWDATA[15:0];
      end
   end

   always_ff @(posedge HCLK) begin
      if (SI_Reset) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + 16'd1;
      bit_d   = bit_q;
      shift_d = shift_q;
      div_d   = div_q;
      pop_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            baud_d = 16'd0;
            bit_d  = 3'd0;
            if (!empty_s) begin
               pop_s   = 1'b1;
               shift_d = mem_q[rptr_q];
               div_d   = bauddiv_q;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_end_s) begin
               baud_d  = 16'd0;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_end_s) begin
               baud_d  = 16'd0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  bit_d   = 3'd0;
                  state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (baud_end_s) begin
               baud_d = 16'd0;
               bit_d  = 3'd0;
               // Back-to-back frames: reload straight into START with no idle gap
               if (!empty_s) begin
                  pop_s   = 1'b1;
                  shift_d = mem_q[rptr_q];
                  div_d   = bauddiv_q;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      irq_d = empty_s & (state_q == S_IDLE);
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (SI_Reset) begin
         baud_q  <= 16'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         div_q   <= 16'(DEFAULT_DIV);
         tx_q    <= 1'b1;
         irq_q   <= 1'b1;
      end else begin
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         div_q   <= div_d;
         tx_q    <= tx_d;
         irq_q   <= irq_d;
      end
   end

   always_comb begin
      status_s          = 32'd0;
      status_s[0]       = full_s;
      status_s[1]       = empty_s;
      status_s[2]       = (state_q != S_IDLE);
      status_s[3]       = ovf_q;
      status_s[8 +: CW] = count_q;
   end

   always_comb begin
      HRDATA = 32'd0;
      if (dp_sel_q && !dp_write_q) begin
         case (dp_addr_q)
            2'd1:    HRDATA = status_s;
            2'd2:    HRDATA = {16'd0, bauddiv_q};
            default: HRDATA = 32'd0;
         endcase
      end else begin
         HRDATA = 32'd0;
      end
   end

endmodule
